// File: rtl/core_pkg.sv
// ---------------------------------------------------------------------------
// core_pkg
// Shared load/store definitions used by the store path:
//   - LSCtrl encodings (LB..SW)
//   - store FSM state encoding
//   - byte/half/word base strobe masks
//   - lane payload struct used for the held second beat
//   - is_store() helper
// Build option: STORE_UNIT_MISALIGN_SPLIT_EN (consumed by store_unit).
// ---------------------------------------------------------------------------
package core_pkg;

    localparam int unsigned LSCTRL_W = 3;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned STRB_W   = 4;

    // Load/store control codes
    localparam logic [LSCTRL_W-1:0] LS_LB  = 3'b000;
    localparam logic [LSCTRL_W-1:0] LS_LH  = 3'b001;
    localparam logic [LSCTRL_W-1:0] LS_LW  = 3'b010;
    localparam logic [LSCTRL_W-1:0] LS_LBU = 3'b011;
    localparam logic [LSCTRL_W-1:0] LS_LHU = 3'b100;
    localparam logic [LSCTRL_W-1:0] LS_SB  = 3'b101;
    localparam logic [LSCTRL_W-1:0] LS_SH  = 3'b110;
    localparam logic [LSCTRL_W-1:0] LS_SW  = 3'b111;

    // Base strobe masks before lane shifting
    localparam logic [STRB_W-1:0] MASK_B = 4'b0001;
    localparam logic [STRB_W-1:0] MASK_H = 4'b0011;
    localparam logic [STRB_W-1:0] MASK_W = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2
    } store_state_t;

    // One write-beat lane payload (data + byte strobes)
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
    } lane_t;

    function automatic logic is_store(input logic [LSCTRL_W-1:0] code);
        return (code == LS_SB) || (code == LS_SH) || (code == LS_SW);
    endfunction

endpackage

// File: rtl/store_align.sv
// ---------------------------------------------------------------------------
// store_align
// Combinational lane generator: places the byte/half/word of the store value
// at the byte offset within a two-word window and flags word-crossing stores.
// Ports:
//   i_lsctrl  in   3   load/store code (non-store codes give zero strobes)
//   i_off     in   2   byte offset addr[1:0]
//   i_wdata   in   32  rs2 value
//   o_strb    out  8   strobes for {beat1, beat0}
//   o_data    out  64  lane-shifted data for {beat1, beat0}
//   o_cross   out  1   store touches the following word
// ---------------------------------------------------------------------------
module store_align
    import core_pkg::*;
(
    input  logic [LSCTRL_W-1:0]   i_lsctrl,
    input  logic [1:0]            i_off,
    input  logic [DATA_W-1:0]     i_wdata,
    output logic [2*STRB_W-1:0]   o_strb,
    output logic [2*DATA_W-1:0]   o_data,
    output logic                  o_cross
);

    logic [STRB_W-1:0] w_mask;
    logic [DATA_W-1:0] w_base;

    // Select base mask and zero-extended base data from the store size
    always_comb begin
        w_mask = '0;
        w_base = '0;
        case (i_lsctrl)
            LS_SB: begin
                w_mask = MASK_B;
                w_base = {24'h0, i_wdata[7:0]};
            end
            LS_SH: begin
                w_mask = MASK_H;
                w_base = {16'h0, i_wdata[15:0]};
            end
            LS_SW: begin
                w_mask = MASK_W;
                w_base = i_wdata;
            end
            default: begin
                w_mask = '0;
                w_base = '0;
            end
        endcase
    end

    assign o_strb  = {4'b0000, w_mask} << i_off;
    assign o_data  = {32'h0, w_base} << {i_off, 3'b000};
    assign o_cross = |o_strb[2*STRB_W-1:STRB_W];

endmodule

// File: rtl/store_unit.sv
// ---------------------------------------------------------------------------
// store_unit
// Converts SB/SH/SW requests into word-aligned data-memory write beats with
// byte strobes over a valid/ready handshake.
// Build option: STORE_UNIT_MISALIGN_SPLIT_EN
//   defined   - word-crossing stores are issued as two beats; err stays 0
//   undefined - word-crossing stores are dropped with a one-cycle err pulse
// Ports:
//   clk, rst    in        clock, asynchronous active-high reset
//   req_valid   in   1    store request present
//   req_ready   out  1    request accepted this edge when high (IDLE only)
//   LSCtrl      in   3    load/store code
//   addr        in   AW   byte address
//   wdata       in   32   store value
//   mem_valid   out  1    write beat valid
//   mem_ready   in   1    memory accepts beat
//   mem_addr    out  AW   word-aligned beat address
//   mem_wdata   out  32   lane-shifted write data
//   mem_wstrb   out  4    byte strobes
//   done        out  1    pulse after final beat of a store is accepted
//   err         out  1    pulse on a rejected crossing store
// ---------------------------------------------------------------------------
module store_unit
    import core_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [LSCTRL_W-1:0]  LSCtrl,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [DATA_W-1:0]    wdata,
    output logic                 mem_valid,
    input  logic                 mem_ready,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [DATA_W-1:0]    mem_wdata,
    output logic [STRB_W-1:0]    mem_wstrb,
    output logic                 done,
    output logic                 err
);

    store_state_t r_state;
    store_state_t w_state_nxt;

    logic                r_req_ready;
    logic                r_mem_valid;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [STRB_W-1:0]   r_mem_wstrb;
    logic                r_done;
    logic                r_err;

    logic                w_req_ready_nxt;
    logic                w_mem_valid_nxt;
    logic [ADDR_W-1:0]   w_mem_addr_nxt;
    logic [DATA_W-1:0]   w_mem_wdata_nxt;
    logic [STRB_W-1:0]   w_mem_wstrb_nxt;
    logic                w_done_nxt;
    logic                w_err_nxt;

    logic [2*STRB_W-1:0] w_strb8;
    logic [2*DATA_W-1:0] w_data64;
    logic                w_cross;
    logic                w_accept;
    logic                w_is_store;
    logic [ADDR_W-1:0]   w_base_addr;

    store_align u_align (
        .i_lsctrl (LSCtrl),
        .i_off    (addr[1:0]),
        .i_wdata  (wdata),
        .o_strb   (w_strb8),
        .o_data   (w_data64),
        .o_cross  (w_cross)
    );

    assign w_accept    = req_valid && r_req_ready;
    assign w_is_store  = is_store(LSCtrl);
    assign w_base_addr = {addr[ADDR_W-1:2], 2'b00};

`ifdef STORE_UNIT_MISALIGN_SPLIT_EN
    lane_t             r_hi;
    logic [ADDR_W-1:0] r_hi_addr;
    logic              r_cross;

    // Second-beat payload is taken at acceptance so later input changes are ignored
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hi      <= '0;
            r_hi_addr <= '0;
            r_cross   <= 1'b0;
        end else if (w_accept) begin
            r_hi.data <= w_data64[2*DATA_W-1:DATA_W];
            r_hi.strb <= w_strb8[2*STRB_W-1:STRB_W];
            r_hi_addr <= w_base_addr + ADDR_W'(4);
            r_cross   <= w_cross;
        end
    end
`else
    logic w_unused_hi;
    assign w_unused_hi = ^{w_data64[2*DATA_W-1:DATA_W], w_strb8[2*STRB_W-1:STRB_W]};
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && w_is_store) begin
`ifdef STORE_UNIT_MISALIGN_SPLIT_EN
                    w_state_nxt = ST_BEAT0;
`else
                    if (!w_cross) begin
                        w_state_nxt = ST_BEAT0;
                    end
`endif
                end
            end
            ST_BEAT0: begin
                if (mem_ready) begin
`ifdef STORE_UNIT_MISALIGN_SPLIT_EN
                    w_state_nxt = r_cross ? ST_BEAT1 : ST_IDLE;
`else
                    w_state_nxt = ST_IDLE;
`endif
                end
            end
`ifdef STORE_UNIT_MISALIGN_SPLIT_EN
            ST_BEAT1: begin
                if (mem_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
`endif
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Next values of the registered outputs; beat fields hold until a new beat loads
    always_comb begin
        w_req_ready_nxt = (w_state_nxt == ST_IDLE);
        w_mem_valid_nxt = (w_state_nxt != ST_IDLE);
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_mem_wstrb_nxt = r_mem_wstrb;
        w_done_nxt      = 1'b0;
        w_err_nxt       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_state_nxt == ST_BEAT0) begin
                    w_mem_addr_nxt  = w_base_addr;
                    w_mem_wdata_nxt = w_data64[DATA_W-1:0];
                    w_mem_wstrb_nxt = w_strb8[STRB_W-1:0];
                end
`ifndef STORE_UNIT_MISALIGN_SPLIT_EN
                if (w_accept && w_is_store && w_cross) begin
                    w_err_nxt = 1'b1;
                end
`endif
            end
            ST_BEAT0: begin
                if (mem_ready) begin
`ifdef STORE_UNIT_MISALIGN_SPLIT_EN
                    if (r_cross) begin
                        w_mem_addr_nxt  = r_hi_addr;
                        w_mem_wdata_nxt = r_hi.data;
                        w_mem_wstrb_nxt = r_hi.strb;
                    end else begin
                        w_done_nxt = 1'b1;
                    end
`else
                    w_done_nxt = 1'b1;
`endif
                end
            end
`ifdef STORE_UNIT_MISALIGN_SPLIT_EN
            ST_BEAT1: begin
                if (mem_ready) begin
                    w_done_nxt = 1'b1;
                end
            end
`endif
            default: begin
                w_done_nxt = 1'b0;
            end
        endcase
    end

    // Output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req_ready <= 1'b1;
            r_mem_valid <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wstrb <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_req_ready <= w_req_ready_nxt;
            r_mem_valid <= w_mem_valid_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_mem_wstrb <= w_mem_wstrb_nxt;
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
        end
    end

    assign req_ready = r_req_ready;
    assign mem_valid = r_mem_valid;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_wstrb = r_mem_wstrb;
    assign done      = r_done;
    assign err       = r_err;

endmodule

// File: tb/tb_store_unit.sv
// ---------------------------------------------------------------------------
// tb_store_unit
// Directed bench for store_unit. Expectations follow the build option
// STORE_UNIT_MISALIGN_SPLIT_EN when it is defined for the compile.
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_store_unit;
    import core_pkg::*;

    localparam int unsigned ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        LSCtrl;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wstrb;
    logic              done;
    logic              err;

    int n_checks = 0;
    int n_errors = 0;

    store_unit #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .LSCtrl    (LSCtrl),
        .addr      (addr),
        .wdata     (wdata),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Present a request for one edge, then scramble the inputs; returns at negedge of N+1
    task automatic issue(input logic [2:0] code, input logic [31:0] a, input logic [31:0] d);
        req_valid = 1'b1;
        LSCtrl    = code;
        addr      = a;
        wdata     = d;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        LSCtrl    = LS_SW;
        addr      = 32'h5555_5557;
        wdata     = 32'hFFFF_FFFF;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if ({req_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb, done, err} !== {1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0}) begin
            n_errors++;
            $display("FAIL reset_state: got rdy=%b v=%b a=%h d=%h s=%b done=%b err=%b exp rdy=1 v=0 a=0 d=0 s=0 done=0 err=0",
                     req_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb, done, err);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({req_ready, mem_valid, done, err} !== 4'b1000) begin
            n_errors++;
            $display("FAIL idle_after_reset: got %b exp 1000", {req_ready, mem_valid, done, err});
        end
    endtask

    task automatic test_sb_off3();
        mem_ready = 1'b1;
        issue(LS_SB, 32'h0000_1003, 32'hAABB_CCDD);
        n_checks++;
        if ({mem_valid, mem_addr, mem_wstrb, mem_wdata, req_ready} !== {1'b1, 32'h1000, 4'b1000, 32'hDD00_0000, 1'b0}) begin
            n_errors++;
            $display("FAIL sb_beat: got v=%b a=%h s=%b d=%h rdy=%b exp v=1 a=00001000 s=1000 d=dd000000 rdy=0",
                     mem_valid, mem_addr, mem_wstrb, mem_wdata, req_ready);
        end
        @(negedge clk);
        n_checks++;
        if ({done, mem_valid, req_ready, err} !== 4'b1010) begin
            n_errors++;
            $display("FAIL sb_done: got done/v/rdy/err=%b exp 1010", {done, mem_valid, req_ready, err});
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0) begin
            n_errors++;
            $display("FAIL sb_done_pulse: got %b exp 0", done);
        end
    endtask

    task automatic test_sh_stall();
        mem_ready = 1'b0;
        issue(LS_SH, 32'h0000_2002, 32'h0000_1234);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({mem_valid, mem_addr, mem_wstrb, mem_wdata, done} !== {1'b1, 32'h2000, 4'b1100, 32'h1234_0000, 1'b0}) begin
                n_errors++;
                $display("FAIL sh_stall_cyc%0d: got v=%b a=%h s=%b d=%h done=%b exp v=1 a=00002000 s=1100 d=12340000 done=0",
                         i, mem_valid, mem_addr, mem_wstrb, mem_wdata, done);
            end
            if (i == 3) mem_ready = 1'b1;
            @(negedge clk);
        end
        n_checks++;
        if ({done, mem_valid, req_ready} !== 3'b101) begin
            n_errors++;
            $display("FAIL sh_done: got done/v/rdy=%b exp 101", {done, mem_valid, req_ready});
        end
    endtask

    task automatic test_sw_cross();
        @(negedge clk);
        mem_ready = 1'b1;
        issue(LS_SW, 32'h0000_3001, 32'h1122_3344);
`ifdef STORE_UNIT_MISALIGN_SPLIT_EN
        n_checks++;
        if ({mem_valid, mem_addr, mem_wstrb, mem_wdata} !== {1'b1, 32'h3000, 4'b1110, 32'h2233_4400}) begin
            n_errors++;
            $display("FAIL sw_beat0: got v=%b a=%h s=%b d=%h exp v=1 a=00003000 s=1110 d=22334400",
                     mem_valid, mem_addr, mem_wstrb, mem_wdata);
        end
        @(negedge clk);
        n_checks++;
        if ({mem_valid, mem_addr, mem_wstrb, mem_wdata, done, req_ready} !== {1'b1, 32'h3004, 4'b0001, 32'h0000_0011, 1'b0, 1'b0}) begin
            n_errors++;
            $display("FAIL sw_beat1: got v=%b a=%h s=%b d=%h done=%b rdy=%b exp v=1 a=00003004 s=0001 d=00000011 done=0 rdy=0",
                     mem_valid, mem_addr, mem_wstrb, mem_wdata, done, req_ready);
        end
        @(negedge clk);
        n_checks++;
        if ({done, mem_valid, req_ready, err} !== 4'b1010) begin
            n_errors++;
            $display("FAIL sw_done: got done/v/rdy/err=%b exp 1010", {done, mem_valid, req_ready, err});
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0) begin
            n_errors++;
            $display("FAIL sw_single_done: got %b exp 0", done);
        end
`else
        n_checks++;
        if ({mem_valid, err, req_ready, done} !== 4'b0110) begin
            n_errors++;
            $display("FAIL sw_reject: got v/err/rdy/done=%b exp 0110", {mem_valid, err, req_ready, done});
        end
        @(negedge clk);
        n_checks++;
        if ({mem_valid, err, req_ready, done} !== 4'b0010) begin
            n_errors++;
            $display("FAIL sw_err_pulse: got v/err/rdy/done=%b exp 0010", {mem_valid, err, req_ready, done});
        end
`endif
    endtask

    task automatic test_sw_wrap();
        @(negedge clk);
        mem_ready = 1'b1;
        issue(LS_SW, 32'hFFFF_FFFE, 32'h1122_3344);
`ifdef STORE_UNIT_MISALIGN_SPLIT_EN
        n_checks++;
        if ({mem_valid, mem_addr, mem_wstrb, mem_wdata} !== {1'b1, 32'hFFFF_FFFC, 4'b1100, 32'h3344_0000}) begin
            n_errors++;
            $display("FAIL wrap_beat0: got v=%b a=%h s=%b d=%h exp v=1 a=fffffffc s=1100 d=33440000",
                     mem_valid, mem_addr, mem_wstrb, mem_wdata);
        end
        @(negedge clk);
        n_checks++;
        if ({mem_valid, mem_addr, mem_wstrb, mem_wdata} !== {1'b1, 32'h0000_0000, 4'b0011, 32'h0000_1122}) begin
            n_errors++;
            $display("FAIL wrap_beat1: got v=%b a=%h s=%b d=%h exp v=1 a=00000000 s=0011 d=00001122",
                     mem_valid, mem_addr, mem_wstrb, mem_wdata);
        end
        @(negedge clk);
        n_checks++;
        if ({done, mem_valid} !== 2'b10) begin
            n_errors++;
            $display("FAIL wrap_done: got done/v=%b exp 10", {done, mem_valid});
        end
`else
        n_checks++;
        if ({mem_valid, err, req_ready} !== 3'b011) begin
            n_errors++;
            $display("FAIL wrap_reject: got v/err/rdy=%b exp 011", {mem_valid, err, req_ready});
        end
        @(negedge clk);
`endif
    endtask

    task automatic test_nonstore();
        @(negedge clk);
        mem_ready = 1'b1;
        issue(LS_LB, 32'h0000_1000, 32'h1234_5678);
        n_checks++;
        if ({mem_valid, done, err, req_ready} !== 4'b0001) begin
            n_errors++;
            $display("FAIL lb_drop: got v/done/err/rdy=%b exp 0001", {mem_valid, done, err, req_ready});
        end
        @(negedge clk);
        n_checks++;
        if ({mem_valid, done, err} !== 3'b000) begin
            n_errors++;
            $display("FAIL lb_no_done: got v/done/err=%b exp 000", {mem_valid, done, err});
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        mem_ready = 1'b1;
        req_valid = 1'b1;
        LSCtrl    = LS_SB;
        addr      = 32'h0000_0010;
        wdata     = 32'h0000_005A;
        @(posedge clk);
        @(negedge clk);
        LSCtrl    = LS_SH;
        addr      = 32'h0000_0022;
        wdata     = 32'h0000_BEEF;
        n_checks++;
        if ({mem_valid, mem_addr, mem_wstrb, mem_wdata, req_ready} !== {1'b1, 32'h10, 4'b0001, 32'h0000_005A, 1'b0}) begin
            n_errors++;
            $display("FAIL b2b_first: got v=%b a=%h s=%b d=%h rdy=%b exp v=1 a=00000010 s=0001 d=0000005a rdy=0",
                     mem_valid, mem_addr, mem_wstrb, mem_wdata, req_ready);
        end
        @(negedge clk);
        n_checks++;
        if ({done, mem_valid, req_ready} !== 3'b101) begin
            n_errors++;
            $display("FAIL b2b_gap: got done/v/rdy=%b exp 101", {done, mem_valid, req_ready});
        end
        @(negedge clk);
        req_valid = 1'b0;
        n_checks++;
        if ({mem_valid, mem_addr, mem_wstrb, mem_wdata, done} !== {1'b1, 32'h20, 4'b1100, 32'hBEEF_0000, 1'b0}) begin
            n_errors++;
            $display("FAIL b2b_second: got v=%b a=%h s=%b d=%h done=%b exp v=1 a=00000020 s=1100 d=beef0000 done=0",
                     mem_valid, mem_addr, mem_wstrb, mem_wdata, done);
        end
        @(negedge clk);
        n_checks++;
        if ({done, mem_valid} !== 2'b10) begin
            n_errors++;
            $display("FAIL b2b_done: got done/v=%b exp 10", {done, mem_valid});
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        mem_ready = 1'b0;
        issue(LS_SW, 32'h0000_4000, 32'hCAFE_F00D);
        n_checks++;
        if ({mem_valid, mem_wstrb, mem_wdata, req_ready} !== {1'b1, 4'b1111, 32'hCAFE_F00D, 1'b0}) begin
            n_errors++;
            $display("FAIL rstmid_beat: got v=%b s=%b d=%h rdy=%b exp v=1 s=1111 d=cafef00d rdy=0",
                     mem_valid, mem_wstrb, mem_wdata, req_ready);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({mem_valid, req_ready, mem_addr, mem_wstrb} !== {1'b0, 1'b1, 32'h0, 4'h0}) begin
            n_errors++;
            $display("FAIL rstmid_async: got v=%b rdy=%b a=%h s=%b exp v=0 rdy=1 a=0 s=0",
                     mem_valid, req_ready, mem_addr, mem_wstrb);
        end
        #1 rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({mem_valid, req_ready, done} !== 3'b010) begin
            n_errors++;
            $display("FAIL rstmid_idle: got v/rdy/done=%b exp 010", {mem_valid, req_ready, done});
        end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        LSCtrl    = LS_LB;
        addr      = '0;
        wdata     = '0;
        mem_ready = 1'b0;

        test_reset();
        test_sb_off3();
        test_sh_stall();
        test_sw_cross();
        test_sw_wrap();
        test_nonstore();
        test_back_to_back();
        test_reset_mid();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
